// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle for sync_fifo_flex: write port, read port, thresholds and error flags.
// The FIFO takes the slave side; the producer/consumer logic takes the master side.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 11
);
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_en;
    logic                   wr_full;
    logic                   almost_full;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_empty;
    logic                   almost_empty;
    logic [DEPTH_WIDTH:0]   af_thresh;
    logic [DEPTH_WIDTH:0]   ae_thresh;
    logic [DEPTH_WIDTH:0]   water_level;
    logic                   overflow;
    logic                   underflow;
    logic                   clr_err;

    modport master (
        output wr_data, wr_en, rd_en, af_thresh, ae_thresh, clr_err,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en, af_thresh, ae_thresh, clr_err,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Parameterised single-clock FIFO with STD or first-word-fall-through read, optional output
// register, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    DEPTH_WIDTH = 11,
    parameter string READ_MODE   = "STD",
    parameter int    OUTPUT_REG  = 0
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_flex_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam bit FWFT  = (READ_MODE == "FWFT");
    localparam bit OREG  = (OUTPUT_REG != 0) && !FWFT;
    localparam logic [DEPTH_WIDTH:0] ONE        = {{DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH_WIDTH:0] FULL_LEVEL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH:0]   wptr, rptr, level, level_next;
    logic [DATA_WIDTH-1:0]  rd_q, rd_out;
    logic                   stage_valid, stage_valid_next, rd_acc_d;
    logic                   wr_full_q, almost_full_q, rd_empty_q, almost_empty_q;
    logic                   overflow_q, underflow_q;
    logic                   wr_acc, pop, mem_rd;

    // In FWFT rd_empty mirrors the prefetch stage, so "pop" covers both read styles; the
    // memory is read either on an accepted STD read or whenever the FWFT stage can take a word.
    always_comb begin
        wr_acc = bus.wr_en & ~wr_full_q;
        pop    = bus.rd_en & ~rd_empty_q;
        if (FWFT) begin
            mem_rd = (~stage_valid | pop) & (wptr != rptr);
        end else begin
            mem_rd = pop;
        end
        stage_valid_next = FWFT & (mem_rd | (stage_valid & ~pop));
        level_next = level;
        if (wr_acc & ~pop) begin
            level_next = level + ONE;
        end else if (pop & ~wr_acc) begin
            level_next = level - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[DEPTH_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // Status flags are registered from level_next so they move together with water_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
            rd_q           <= '0;
            rd_out         <= '0;
            rd_acc_d       <= 1'b0;
            stage_valid    <= 1'b0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (mem_rd) begin
                rptr <= rptr + ONE;
                rd_q <= mem[rptr[DEPTH_WIDTH-1:0]];
            end
            rd_acc_d <= mem_rd & OREG;
            if (rd_acc_d) begin
                rd_out <= rd_q;
            end
            stage_valid    <= stage_valid_next;
            level          <= level_next;
            wr_full_q      <= (level_next == FULL_LEVEL);
            almost_full_q  <= (level_next >= bus.af_thresh);
            almost_empty_q <= (level_next <= bus.ae_thresh);
            rd_empty_q     <= FWFT ? ~stage_valid_next : (level_next == '0);
            overflow_q     <= (bus.wr_en & wr_full_q) | (overflow_q & ~bus.clr_err);
            underflow_q    <= (bus.rd_en & rd_empty_q) | (underflow_q & ~bus.clr_err);
        end
    end

    assign bus.rd_data      = OREG ? rd_out : rd_q;
    assign bus.wr_full      = wr_full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.water_level  = level;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: STD, FWFT and STD+output-register instances checked against
// queue-based reference models.
module tb_sync_fifo_flex;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    typedef logic [AW:0] lvl_t;
    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   af_t, ae_t;

    logic [DW-1:0] s_q[$];
    logic          s_ovf, s_unf;
    logic [DW-1:0] s_last;
    ent_t          f_q[$];
    int            f_edge = 0;
    int            f_last_pop;
    logic          f_ovf, f_unf;
    logic [DW-1:0] f_shown;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) s_if ();
    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) f_if ();
    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) o_if ();

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .READ_MODE("STD"), .OUTPUT_REG(0))
        u_std (.clk(clk), .rst(rst), .bus(s_if));
    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .READ_MODE("FWFT"), .OUTPUT_REG(0))
        u_fwft (.clk(clk), .rst(rst), .bus(f_if));
    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .READ_MODE("STD"), .OUTPUT_REG(1))
        u_oreg (.clk(clk), .rst(rst), .bus(o_if));

    task automatic idle_inputs();
        s_if.wr_en = 0; s_if.rd_en = 0; s_if.clr_err = 0; s_if.wr_data = '0;
        f_if.wr_en = 0; f_if.rd_en = 0; f_if.clr_err = 0; f_if.wr_data = '0;
        o_if.wr_en = 0; o_if.rd_en = 0; o_if.clr_err = 0; o_if.wr_data = '0;
    endtask

    task automatic set_thresh(input int af, input int ae);
        af_t = af; ae_t = ae;
        s_if.af_thresh = lvl_t'(af); s_if.ae_thresh = lvl_t'(ae);
        f_if.af_thresh = lvl_t'(af); f_if.ae_thresh = lvl_t'(ae);
        o_if.af_thresh = lvl_t'(af); o_if.ae_thresh = lvl_t'(ae);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s_q.delete(); s_ovf = 0; s_unf = 0; s_last = '0;
        f_q.delete(); f_ovf = 0; f_unf = 0; f_shown = '0; f_last_pop = -100;
    endtask

    function automatic bit f_valid();
        return (f_q.size() > 0) && (f_q[0].rdy <= f_edge);
    endfunction

    // STD model: a plain queue; the read data is whatever left the queue last.
    task automatic step_std(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        bit full, empty;
        s_if.wr_en = wr; s_if.wr_data = d; s_if.rd_en = rd; s_if.clr_err = clr;
        full  = (s_q.size() == DEPTH);
        empty = (s_q.size() == 0);
        @(posedge clk);
        if (rd && !empty) s_last = s_q.pop_front();
        if (wr && !full) s_q.push_back(d);
        s_ovf = (wr && full)  ? 1'b1 : (clr ? 1'b0 : s_ovf);
        s_unf = (rd && empty) ? 1'b1 : (clr ? 1'b0 : s_unf);
        #1;
        s_if.wr_en = 0; s_if.rd_en = 0; s_if.clr_err = 0;
    endtask

    // FWFT model: a word is shown one edge after it is written to memory, and never before
    // the edge on which its predecessor was popped.
    task automatic step_fwft(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        bit valid, full;
        int r;
        f_if.wr_en = wr; f_if.wr_data = d; f_if.rd_en = rd; f_if.clr_err = clr;
        valid = f_valid();
        full  = (f_q.size() == DEPTH);
        @(posedge clk);
        f_edge++;
        if (rd && valid) begin
            void'(f_q.pop_front());
            f_last_pop = f_edge;
            if (f_q.size() > 0 && f_q[0].rdy < f_edge) f_q[0].rdy = f_edge;
        end
        if (wr && !full) begin
            r = (f_edge + 1 > f_last_pop) ? f_edge + 1 : f_last_pop;
            f_q.push_back(ent_t'{d, r});
        end
        f_ovf = (wr && full)  ? 1'b1 : (clr ? 1'b0 : f_ovf);
        f_unf = (rd && !valid) ? 1'b1 : (clr ? 1'b0 : f_unf);
        #1;
        if (f_valid()) f_shown = f_q[0].d;
        f_if.wr_en = 0; f_if.rd_en = 0; f_if.clr_err = 0;
    endtask

    task automatic test_reset();
        n_tests++; if (s_if.water_level !== lvl_t'(0)) begin n_fail++; $display("[TB] FAIL rst_level got %0d want 0", s_if.water_level); end
        n_tests++; if (s_if.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_rd_empty got %b want 1", s_if.rd_empty); end
        n_tests++; if (s_if.almost_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_almost_empty got %b want 1", s_if.almost_empty); end
        n_tests++; if (s_if.wr_full !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wr_full got %b want 0", s_if.wr_full); end
        n_tests++; if (s_if.almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_almost_full got %b want 0", s_if.almost_full); end
        n_tests++; if ({s_if.overflow, s_if.underflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_err_flags got %b%b want 00", s_if.overflow, s_if.underflow); end
        n_tests++; if (s_if.rd_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_rd_data got %h want 00", s_if.rd_data); end
        n_tests++; if (f_if.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_fwft_empty got %b want 1", f_if.rd_empty); end
        n_tests++; if (o_if.rd_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_oreg_data got %h want 00", o_if.rd_data); end
        reset_all();
    endtask

    task automatic test_std_fill_drain();
        reset_all();
        set_thresh(14, 2);
        for (int i = 0; i < 16; i++) begin
            step_std(1'b1, 8'(i), 1'b0, 1'b0);
            n_tests++; if (s_if.water_level !== lvl_t'(i + 1)) begin n_fail++; $display("[TB] FAIL fill_level i=%0d got %0d want %0d", i, s_if.water_level, i + 1); end
            n_tests++; if (s_if.almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("[TB] FAIL fill_almost_empty i=%0d got %b", i, s_if.almost_empty); end
            n_tests++; if (s_if.almost_full !== (i + 1 >= 14)) begin n_fail++; $display("[TB] FAIL fill_almost_full i=%0d got %b", i, s_if.almost_full); end
            n_tests++; if (s_if.wr_full !== (i == 15)) begin n_fail++; $display("[TB] FAIL fill_wr_full i=%0d got %b", i, s_if.wr_full); end
        end
        step_std(1'b1, 8'hEE, 1'b0, 1'b0);
        n_tests++; if (s_if.overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_overflow got %b want 1", s_if.overflow); end
        n_tests++; if (s_if.water_level !== lvl_t'(16)) begin n_fail++; $display("[TB] FAIL fill_level_after_ovf got %0d want 16", s_if.water_level); end
        for (int i = 0; i < 16; i++) begin
            step_std(1'b0, 8'h00, 1'b1, 1'b0);
            n_tests++; if (s_if.rd_data !== 8'(i)) begin n_fail++; $display("[TB] FAIL drain_data i=%0d got %h want %h", i, s_if.rd_data, 8'(i)); end
            n_tests++; if (s_if.water_level !== lvl_t'(15 - i)) begin n_fail++; $display("[TB] FAIL drain_level i=%0d got %0d want %0d", i, s_if.water_level, 15 - i); end
        end
        n_tests++; if (s_if.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_rd_empty got %b want 1", s_if.rd_empty); end
        n_tests++; if (s_if.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_underflow got %b want 0", s_if.underflow); end
    endtask

    task automatic test_thresholds();
        reset_all();
        set_thresh(14, 2);
        for (int i = 0; i < 12; i++) step_std(1'b1, 8'($urandom), 1'b0, 1'b0);
        n_tests++; if (s_if.almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL thr_af_at12 got %b want 0", s_if.almost_full); end
        set_thresh(10, 2);
        step_std(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++; if (s_if.almost_full !== 1'b1) begin n_fail++; $display("[TB] FAIL thr_af_lowered got %b want 1", s_if.almost_full); end
        set_thresh(14, 12);
        step_std(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++; if ({s_if.almost_full, s_if.almost_empty} !== 2'b01) begin n_fail++; $display("[TB] FAIL thr_raised got af=%b ae=%b want af=0 ae=1", s_if.almost_full, s_if.almost_empty); end
        set_thresh(14, 2);
    endtask

    task automatic test_fwft_basic();
        logic [DW-1:0] vals[4];
        reset_all();
        step_fwft(1'b1, 8'hA5, 1'b0, 1'b0);
        n_tests++; if (f_if.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fwft_n1_empty got %b want 1", f_if.rd_empty); end
        step_fwft(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++; if (f_if.rd_empty !== 1'b0) begin n_fail++; $display("[TB] FAIL fwft_n2_empty got %b want 0", f_if.rd_empty); end
        n_tests++; if (f_if.rd_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL fwft_n2_data got %h want a5", f_if.rd_data); end
        n_tests++; if (f_if.water_level !== lvl_t'(1)) begin n_fail++; $display("[TB] FAIL fwft_n2_level got %0d want 1", f_if.water_level); end
        step_fwft(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++; if ({f_if.rd_empty, f_if.water_level} !== {1'b1, lvl_t'(0)}) begin n_fail++; $display("[TB] FAIL fwft_pop got empty=%b level=%0d want 1/0", f_if.rd_empty, f_if.water_level); end
        for (int i = 0; i < 4; i++) begin
            vals[i] = 8'($urandom_range(1, 255));
            step_fwft(1'b1, vals[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({f_if.rd_empty, f_if.rd_data} !== {1'b0, vals[i]}) begin n_fail++; $display("[TB] FAIL fwft_b2b i=%0d got empty=%b data=%h want 0/%h", i, f_if.rd_empty, f_if.rd_data, vals[i]); end
            step_fwft(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_tests++; if (f_if.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fwft_b2b_end got %b want 1", f_if.rd_empty); end
    endtask

    task automatic test_simul_wrap();
        reset_all();
        for (int i = 0; i < 8; i++) step_std(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int c = 0; c < 100; c++) begin
            step_std(1'b1, 8'($urandom), 1'b1, 1'b0);
            n_tests++; if (s_if.water_level !== lvl_t'(8)) begin n_fail++; $display("[TB] FAIL wrap_level c=%0d got %0d want 8", c, s_if.water_level); end
            n_tests++; if (s_if.rd_data !== s_last) begin n_fail++; $display("[TB] FAIL wrap_data c=%0d got %h want %h", c, s_if.rd_data, s_last); end
        end
        for (int i = 0; i < 8; i++) step_std(1'b1, 8'($urandom), 1'b0, 1'b0);
        step_std(1'b1, 8'h5A, 1'b1, 1'b0);
        n_tests++; if (s_if.water_level !== lvl_t'(15)) begin n_fail++; $display("[TB] FAIL full_rw_level got %0d want 15", s_if.water_level); end
        n_tests++; if (s_if.overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL full_rw_overflow got %b want 1", s_if.overflow); end
        n_tests++; if (s_if.rd_data !== s_last) begin n_fail++; $display("[TB] FAIL full_rw_data got %h want %h", s_if.rd_data, s_last); end
    endtask

    task automatic test_reset_mid();
        reset_all();
        step_std(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step_std(1'b1, 8'($urandom), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (s_if.water_level !== lvl_t'(0)) begin n_fail++; $display("[TB] FAIL mid_rst_level got %0d want 0", s_if.water_level); end
        n_tests++; if ({s_if.rd_empty, s_if.almost_empty} !== 2'b11) begin n_fail++; $display("[TB] FAIL mid_rst_empty got %b%b want 11", s_if.rd_empty, s_if.almost_empty); end
        n_tests++; if (s_if.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_underflow got %b want 0", s_if.underflow); end
        reset_all();
        step_std(1'b1, 8'h3C, 1'b0, 1'b0);
        step_std(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++; if ({s_if.rd_data, s_if.water_level} !== {8'h3C, lvl_t'(0)}) begin n_fail++; $display("[TB] FAIL mid_rst_readback got %h/%0d want 3c/0", s_if.rd_data, s_if.water_level); end
    endtask

    task automatic test_errors();
        reset_all();
        step_std(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (s_if.underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL err_underflow got %b want 1", s_if.underflow); end
        step_std(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++; if (s_if.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear got %b want 0", s_if.underflow); end
        step_std(1'b0, 8'h00, 1'b1, 1'b1);
        n_tests++; if (s_if.underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set_wins got %b want 1", s_if.underflow); end
        step_std(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++; if (s_if.underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky got %b want 1", s_if.underflow); end
    endtask

    task automatic test_output_reg();
        logic [DW-1:0] w[3];
        reset_all();
        for (int i = 0; i < 3; i++) begin
            w[i] = 8'($urandom_range(1, 255));
            o_if.wr_en = 1'b1; o_if.wr_data = w[i];
            @(posedge clk); #1;
        end
        o_if.wr_en = 1'b0; o_if.rd_en = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (o_if.rd_data !== 8'h00) begin n_fail++; $display("[TB] FAIL oreg_lat1 got %h want 00", o_if.rd_data); end
        @(posedge clk); #1;
        n_tests++; if (o_if.rd_data !== w[0]) begin n_fail++; $display("[TB] FAIL oreg_w0 got %h want %h", o_if.rd_data, w[0]); end
        @(posedge clk); #1;
        n_tests++; if (o_if.rd_data !== w[1]) begin n_fail++; $display("[TB] FAIL oreg_w1 got %h want %h", o_if.rd_data, w[1]); end
        o_if.rd_en = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (o_if.rd_data !== w[2]) begin n_fail++; $display("[TB] FAIL oreg_w2 got %h want %h", o_if.rd_data, w[2]); end
        @(posedge clk); #1;
        n_tests++; if ({o_if.rd_data, o_if.rd_empty} !== {w[2], 1'b1}) begin n_fail++; $display("[TB] FAIL oreg_hold got %h/%b want %h/1", o_if.rd_data, o_if.rd_empty, w[2]); end
    endtask

    task automatic test_random();
        int p_wr, n;
        reset_all();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) set_thresh($urandom_range(0, 16), $urandom_range(0, 16));
            p_wr = (c / 100) % 2 == 0 ? 75 : 25;
            step_std($urandom_range(0, 99) < p_wr, 8'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 15) == 0);
            n = s_q.size();
            n_tests++; if (s_if.water_level !== lvl_t'(n)) begin n_fail++; $display("[TB] FAIL rnd_std_level c=%0d got %0d want %0d", c, s_if.water_level, n); end
            n_tests++; if ({s_if.wr_full, s_if.rd_empty} !== {n == DEPTH, n == 0}) begin n_fail++; $display("[TB] FAIL rnd_std_full_empty c=%0d got %b%b", c, s_if.wr_full, s_if.rd_empty); end
            n_tests++; if ({s_if.almost_full, s_if.almost_empty} !== {n >= af_t, n <= ae_t}) begin n_fail++; $display("[TB] FAIL rnd_std_almost c=%0d got %b%b lvl=%0d af=%0d ae=%0d", c, s_if.almost_full, s_if.almost_empty, n, af_t, ae_t); end
            n_tests++; if (s_if.rd_data !== s_last) begin n_fail++; $display("[TB] FAIL rnd_std_data c=%0d got %h want %h", c, s_if.rd_data, s_last); end
            n_tests++; if ({s_if.overflow, s_if.underflow} !== {s_ovf, s_unf}) begin n_fail++; $display("[TB] FAIL rnd_std_err c=%0d got %b%b want %b%b", c, s_if.overflow, s_if.underflow, s_ovf, s_unf); end
        end
        reset_all();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) set_thresh($urandom_range(0, 16), $urandom_range(0, 16));
            p_wr = (c / 100) % 2 == 0 ? 75 : 25;
            step_fwft($urandom_range(0, 99) < p_wr, 8'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 15) == 0);
            n = f_q.size();
            n_tests++; if (f_if.water_level !== lvl_t'(n)) begin n_fail++; $display("[TB] FAIL rnd_fwft_level c=%0d got %0d want %0d", c, f_if.water_level, n); end
            n_tests++; if ({f_if.wr_full, f_if.rd_empty} !== {n == DEPTH, !f_valid()}) begin n_fail++; $display("[TB] FAIL rnd_fwft_full_empty c=%0d got %b%b", c, f_if.wr_full, f_if.rd_empty); end
            n_tests++; if ({f_if.almost_full, f_if.almost_empty} !== {n >= af_t, n <= ae_t}) begin n_fail++; $display("[TB] FAIL rnd_fwft_almost c=%0d got %b%b lvl=%0d af=%0d ae=%0d", c, f_if.almost_full, f_if.almost_empty, n, af_t, ae_t); end
            n_tests++; if (f_if.rd_data !== f_shown) begin n_fail++; $display("[TB] FAIL rnd_fwft_data c=%0d got %h want %h", c, f_if.rd_data, f_shown); end
            n_tests++; if ({f_if.overflow, f_if.underflow} !== {f_ovf, f_unf}) begin n_fail++; $display("[TB] FAIL rnd_fwft_err c=%0d got %b%b want %b%b", c, f_if.overflow, f_if.underflow, f_ovf, f_unf); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_thresh(14, 2);
        #3;
        test_reset();
        test_std_fill_drain();
        test_thresholds();
        test_fwft_basic();
        test_simul_wrap();
        test_reset_mid();
        test_errors();
        test_output_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parameterised synchronous FIFO: the next generation of the sync_fifo_2048x8b wrapper.
- Generalises data width and depth and adds a selectable read mode (standard or first-word-fall-through) and an optional output register.
- Adds runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Behavioural memory array, inferred to DRM by synthesis; used in stream buffering between single-clock pipeline stages.

Parameters:
DATA_WIDTH, 8, data word width (1..1152)
DEPTH_WIDTH, 11, log2 of depth; depth = 2**DEPTH_WIDTH (4..20)
READ_MODE, "STD", "STD" standard read or "FWFT" first-word-fall-through
OUTPUT_REG, 0, 1 = extra rd_data register stage (STD mode only; ignored in FWFT)

Ports:
clk  in  1  single clock for all logic, rising edge
rst  in  1  asynchronous active-high reset
wr_data  in  DATA_WIDTH  write data
wr_en  in  1  write request
wr_full  out  1  FIFO full
almost_full  out  1  water_level >= af_thresh
rd_en  in  1  read request (STD) / pop acknowledge (FWFT)
rd_data  out  DATA_WIDTH  read data
rd_empty  out  1  STD: no words stored; FWFT: rd_data not valid
almost_empty  out  1  water_level <= ae_thresh
af_thresh  in  DEPTH_WIDTH+1  almost-full threshold, quasi-static
ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold, quasi-static
water_level  out  DEPTH_WIDTH+1  words held, 0..2**DEPTH_WIDTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset values (async, immediate): wptr = 0, rptr = 0, water_level = 0, wr_full = 0, almost_full = 0, rd_empty = 1, almost_empty = 1, overflow = 0, underflow = 0, rd_data = 0, FWFT valid stage cleared. Memory contents are not cleared.
- Reset mid-operation: state is discarded instantly; no accepted write or read survives. The first write after release follows the normal latency.
- Pointers are DEPTH_WIDTH+1 bits and wrap naturally. Memory address = low DEPTH_WIDTH bits.
- Write accepted = wr_en & ~wr_full. A write while full is dropped, sets overflow, and leaves pointer and memory unchanged, even if a read occurs in the same cycle.
- Read accepted = rd_en & ~rd_empty. A read while rd_empty is ignored and sets underflow.
- water_level is registered: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write or on neither.
- Status flags are registered and computed from the next-cycle level, so they change in the same cycle as water_level:
  - wr_full = (level == 2**DEPTH_WIDTH)
  - almost_full = (level >= af_thresh)
  - almost_empty = (level <= ae_thresh)
- Simultaneous read and write at level 0 in STD mode: the read is rejected (rd_empty = 1) and the write is accepted.
- STD mode:
  - rd_empty = (level == 0).
  - rd_data is valid 1 cycle after an accepted read (OUTPUT_REG = 0) or 2 cycles after (OUTPUT_REG = 1), and holds its value otherwise.
  - First write → rd_empty deasserts on the next cycle.
- FWFT mode:
  - A prefetch stage moves the head word to rd_data whenever the stage is empty or being popped and memory is non-empty.
  - rd_empty = ~stage_valid.
  - Write in cycle N to an empty FIFO → rd_empty = 0 and rd_data = that word at cycle N+2.
  - Accepted rd_en pops; the next word, if any, is presented the following cycle with no bubble.
  - water_level counts all words including the one presented on rd_data.
- Threshold inputs may change at any time; they take effect at the next level update or at the next edge, whichever is first.
- overflow/underflow: set on the offending cycle (visible the next cycle), held until clr_err or rst. If set and clr_err occur in the same cycle, set wins.

Test Plan:
- DW=8, DEPTH_WIDTH=4, STD: write 16 words 0x00..0x0F → wr_full = 1 after the 16th, water_level = 16. 17th write → overflow = 1, contents unchanged. Read 16 → data 0x00..0x0F in order, rd_empty = 1, level = 0.
- FWFT: single write 0xA5 at cycle N → rd_empty = 0, rd_data = 0xA5 at N+2. rd_en pop → rd_empty = 1 the next cycle. Back-to-back 4 writes then 4 pops on consecutive cycles → no bubbles.
- af_thresh = 14, ae_thresh = 2: fill 0→16 → almost_empty drops when level = 3, almost_full rises when level = 14. Change af_thresh to 10 at level 12 → almost_full = 1 the next cycle.
- Simultaneous rd_en/wr_en at level 8 for 100 cycles with pointer wrap → level stays 8, data order preserved across wrap. At level 16 with rd_en & wr_en → write dropped, overflow = 1, level = 15.
- Assert rst mid-burst at level 9 → immediately level = 0, rd_empty = 1, flags cleared. A write after release is read back correctly.
- rd_en on an empty FIFO → underflow = 1. clr_err pulse → 0. clr_err coincident with a new underflow → remains 1.
